// File: rtl/ddr100_phy_pkg.sv
// Shared types and helpers for the DDR PHY read path.
// Pure declarations: no latency, no flow control.
package ddr100_phy_pkg;

    localparam int RSEL_W  = 12;
    localparam int SAMPLES = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        DONE    = ST_DONE
    } rd_state_t;

    // Lowest set bit wins; an all-zero select falls back to phase 0.
    function automatic logic [3:0] rsel_index(input logic [RSEL_W-1:0] r);
        logic [3:0] idx;
        idx = '0;
        for (int i = RSEL_W - 1; i >= 0; i--) begin
            if (r[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic rsel_onehot(input logic [RSEL_W-1:0] r);
        return (r != '0) && ((r & (r - RSEL_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/ddr100_phy_dq_rdcap_if.sv
// Byte-lane read-capture bus between the DQS stage / controller and the capture block.
// Plain wires: no latency, no backpressure (the PHY side cannot be stalled).
interface ddr100_phy_dq_rdcap_if
    import ddr100_phy_pkg::*;
#(
    parameter int DQ_WIDTH = 8
);
    logic [SAMPLES*DQ_WIDTH-1:0] p_dq_in;
    logic [RSEL_W-1:0]           rsel;
    logic                        rvalid;
    logic                        burst8;
    logic                        rd_err_clr;
    logic [2*DQ_WIDTH-1:0]       rdata;
    logic                        rdata_valid;
    logic [8*DQ_WIDTH-1:0]       rd_burst;
    logic                        rd_burst_valid;
    logic                        rd_err;

    modport master (
        output p_dq_in, rsel, rvalid, burst8, rd_err_clr,
        input  rdata, rdata_valid, rd_burst, rd_burst_valid, rd_err
    );

    modport slave (
        input  p_dq_in, rsel, rvalid, burst8, rd_err_clr,
        output rdata, rdata_valid, rd_burst, rd_burst_valid, rd_err
    );
endinterface

// File: rtl/ddr100_phy_dq_bitsel.sv
// One DQ pin: 32-sample history (MSB oldest) and the 12-phase centre-sample mux.
// History registered once from the IDES8 word; mux is combinational; never stalls.
module ddr100_phy_dq_bitsel
    import ddr100_phy_pkg::*;
#(
    parameter int CTR_B = 10,
    parameter int CTR_A = 14
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [SAMPLES-1:0] dq_i,
    input  logic [3:0]         sel_i,
    output logic               early_o,
    output logic               late_o
);
    logic [4*SAMPLES-1:0] hist_q;
    logic [4:0]           idx_a;
    logic [4:0]           idx_b;

    // Shifting a whole word in keeps bit 7 (earliest) above bit 0 (latest).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[3*SAMPLES-1:0], dq_i};
        end
    end

    assign idx_a   = 5'(CTR_A) + {1'b0, sel_i};
    assign idx_b   = 5'(CTR_B) + {1'b0, sel_i};
    assign early_o = hist_q[idx_a];
    assign late_o  = hist_q[idx_b];

endmodule

// File: rtl/ddr100_phy_dq_rdcap.sv
// Byte-lane read capture: centre-sample beat pairs (1 cycle), BL4/BL8 burst assembly.
// No backpressure: rdata and rd_burst are pulse-qualified; a gap mid-burst aborts it.
module ddr100_phy_dq_rdcap
    import ddr100_phy_pkg::*;
#(
    parameter int DQ_WIDTH = 8,
    parameter int CTR_B    = 10,
    parameter int CTR_A    = 14
) (
    input logic                   clk100m,
    input logic                   phy_rst,
    ddr100_phy_dq_rdcap_if.slave  bus
);
    localparam int PW = 2 * DQ_WIDTH;
    localparam int BW = 8 * DQ_WIDTH;

    logic [3:0]          sel_idx;
    logic                sel_ok;
    logic [DQ_WIDTH-1:0] beat_early;
    logic [DQ_WIDTH-1:0] beat_late;
    logic [PW-1:0]       pair;

    logic [PW-1:0]       rdata_q;
    logic                rdata_valid_q;
    rd_state_t           state_q;
    logic [1:0]          cnt_q;
    logic                bl8_q;
    logic [BW-1:0]       burst_q;
    logic                burst_vld_q;
    logic                rd_err_q;
    logic                rd_err_d;
    logic                drop;
    logic                err_new;

    assign sel_idx = rsel_index(bus.rsel);
    assign sel_ok  = rsel_onehot(bus.rsel);

    for (genvar j = 0; j < DQ_WIDTH; j++) begin : g_pin
        ddr100_phy_dq_bitsel #(
            .CTR_B (CTR_B),
            .CTR_A (CTR_A)
        ) u_bitsel (
            .clk_i   (clk100m),
            .rst_i   (phy_rst),
            .dq_i    (bus.p_dq_in[SAMPLES*j +: SAMPLES]),
            .sel_i   (sel_idx),
            .early_o (beat_early[j]),
            .late_o  (beat_late[j])
        );
    end

    assign pair = {beat_late, beat_early};

    always_ff @(posedge clk100m) begin
        if (phy_rst) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_valid_q <= bus.rvalid;
            if (bus.rvalid) rdata_q <= pair;
        end
    end

    // A fresh error outranks a clear landing in the same cycle.
    assign drop     = (state_q == COLLECT) && !bus.rvalid;
    assign err_new  = (bus.rvalid && !sel_ok) || drop;
    assign rd_err_d = err_new | (rd_err_q & ~bus.rd_err_clr);

    always_ff @(posedge clk100m) begin
        if (phy_rst) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= rd_err_d;
        end
    end

    always_ff @(posedge clk100m) begin
        if (phy_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bl8_q       <= 1'b0;
            burst_q     <= '0;
            burst_vld_q <= 1'b0;
        end else begin
            burst_vld_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (bus.rvalid) begin
                        burst_q[int'(cnt_q)*PW +: PW] <= pair;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == (bl8_q ? 2'd3 : 2'd1)) begin
                            state_q     <= DONE;
                            burst_vld_q <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        burst_q <= '0;
                    end
                end
                // IDLE and DONE both accept a new burst start, so back-to-back has no bubble.
                default: begin
                    if (bus.rvalid) begin
                        bl8_q   <= bus.burst8;
                        burst_q <= BW'(pair);
                        cnt_q   <= 2'd1;
                        state_q <= COLLECT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.rdata          = rdata_q;
    assign bus.rdata_valid    = rdata_valid_q;
    assign bus.rd_burst       = burst_q;
    assign bus.rd_burst_valid = burst_vld_q;
    assign bus.rd_err         = rd_err_q;

endmodule

// File: tb/tb_ddr100_phy_dq_rdcap.sv
// Bench for ddr100_phy_dq_rdcap: scheduled stimulus against a sample-stream reference model.
module tb_ddr100_phy_dq_rdcap;
    localparam int DQW  = 8;
    localparam int CB   = 10;
    localparam int CA   = 14;
    localparam int MAXC = 4096;
    localparam int MAXP = 256;

    logic clk100m = 1'b0;
    logic phy_rst = 1'b1;

    ddr100_phy_dq_rdcap_if #(.DQ_WIDTH(DQW)) bus ();

    ddr100_phy_dq_rdcap #(.DQ_WIDTH(DQW), .CTR_B(CB), .CTR_A(CA)) dut (
        .clk100m (clk100m),
        .phy_rst (phy_rst),
        .bus     (bus)
    );

    always #5 clk100m = ~clk100m;

    typedef struct {
        logic [63:0] dq;
        logic [11:0] rs;
        logic        rv;
        logic        b8;
        logic        clr;
        logic        rst;
    } stim_t;

    stim_t       stq[$];
    logic [63:0] words [MAXC];
    int          cyc = 0;
    int          rst_cyc = -1;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_pl = 0;

    logic [15:0] ob_rdata [MAXP], ex_rdata [MAXP];
    logic [63:0] ob_burst [MAXP], ex_burst [MAXP];
    logic        ob_rdv [MAXP], ex_rdv [MAXP];
    logic        ob_bv [MAXP], ex_bv [MAXP];
    logic        ob_err [MAXP], ex_err [MAXP];

    int          m_left = 0;
    int          m_pos = 0;
    logic [63:0] m_burst = '0;
    logic [15:0] m_rdata = '0;
    logic        m_err = 1'b0;

    // Sample n of pin j in the global per-pin stream; word c carries samples 8c..8c+7, bit 7 first.
    function automatic logic samp(int j, int n);
        if (n < 0) return 1'b0;
        if (n / 8 <= rst_cyc) return 1'b0;
        return words[n/8][8*j + 7 - (n % 8)];
    endfunction

    function automatic logic [15:0] model_pair(int n_cyc, int s);
        logic [15:0] p;
        for (int j = 0; j < DQW; j++) begin
            p[j]       = samp(j, 8*n_cyc - 1 - (CA + s));
            p[DQW + j] = samp(j, 8*n_cyc - 1 - (CB + s));
        end
        return p;
    endfunction

    function automatic int low_idx(logic [11:0] r);
        for (int i = 0; i < 12; i++) if (r[i]) return i;
        return 0;
    endfunction

    function automatic logic [63:0] beat_word(int c, int t0, logic [7:0] bt[16], int nb);
        logic [63:0] w;
        int n;
        int k;
        w = {$urandom, $urandom};
        for (int j = 0; j < DQW; j++) begin
            for (int m = 0; m < 8; m++) begin
                n = 8*c + m;
                k = n - t0;
                if (k >= 0 && k < 4*nb) w[8*j + 7 - m] = bt[k/4][j];
            end
        end
        return w;
    endfunction

    task automatic add(logic [63:0] dq, logic [11:0] rs, logic rv, logic b8, logic clr, logic rst);
        stim_t st;
        st.dq = dq; st.rs = rs; st.rv = rv; st.b8 = b8; st.clr = clr; st.rst = rst;
        stq.push_back(st);
    endtask

    // Beats of 4 samples placed so that phase s centres on them; pairs presented from entry +4.
    task automatic add_burst(logic [7:0] bt[16], int nb, int s, logic b8, int npr, int tail);
        int c0;
        int t0;
        logic rv;
        c0 = cyc + stq.size();
        t0 = 8*(c0 + 4) - 17 - s;
        for (int i = 0; i < 4 + npr + tail; i++) begin
            rv = (i >= 4) && (i < 4 + npr);
            add(beat_word(c0 + i, t0, bt, nb), rv ? 12'(1 << s) : 12'($urandom), rv, b8, 1'b0, 1'b0);
        end
    endtask

    task automatic play();
        stim_t st;
        logic [15:0] pr;
        logic nerr;
        n_pl = stq.size();
        for (int i = 0; i < n_pl; i++) begin
            st = stq[i];
            bus.p_dq_in = st.dq; bus.rsel = st.rs; bus.rvalid = st.rv;
            bus.burst8 = st.b8; bus.rd_err_clr = st.clr; phy_rst = st.rst;
            words[cyc] = st.dq;
            pr = model_pair(cyc, low_idx(st.rs));
            ex_bv[i] = 1'b0;
            if (st.rst) begin
                m_left = 0; m_burst = '0; m_rdata = '0; m_err = 1'b0;
                ex_rdv[i] = 1'b0;
                rst_cyc = cyc;
            end else begin
                nerr = st.rv && ($countones(st.rs) != 1);
                ex_rdv[i] = st.rv;
                if (st.rv) m_rdata = pr;
                if (m_left > 0) begin
                    if (st.rv) begin
                        m_burst[16*m_pos +: 16] = pr;
                        m_pos++;
                        m_left--;
                        if (m_left == 0) ex_bv[i] = 1'b1;
                    end else begin
                        m_left = 0;
                        nerr = 1'b1;
                    end
                end else if (st.rv) begin
                    m_burst = {48'b0, pr};
                    m_pos = 1;
                    m_left = st.b8 ? 3 : 1;
                end
                m_err = nerr | (m_err & !st.clr);
            end
            ex_rdata[i] = m_rdata; ex_burst[i] = m_burst; ex_err[i] = m_err;
            @(posedge clk100m);
            #1;
            ob_rdata[i] = bus.rdata; ob_rdv[i] = bus.rdata_valid;
            ob_burst[i] = bus.rd_burst; ob_bv[i] = bus.rd_burst_valid; ob_err[i] = bus.rd_err;
            cyc++;
        end
        stq.delete();
    endtask

    task automatic test_reset();
        repeat (3) add({$urandom, $urandom}, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1);
        play();
        n_tests += 5;
        if (ob_rdata[2] !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", ob_rdata[2]); end
        if (ob_rdv[2] !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_valid got %b want 0", ob_rdv[2]); end
        if (ob_burst[2] !== 64'h0) begin n_fail++; $display("FAIL reset_burst got %h want 0", ob_burst[2]); end
        if (ob_bv[2] !== 1'b0) begin n_fail++; $display("FAIL reset_burst_valid got %b want 0", ob_bv[2]); end
        if (ob_err[2] !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", ob_err[2]); end
    endtask

    task automatic test_const_phase();
        logic [7:0] bt[16];
        for (int k = 0; k < 16; k++) bt[k] = 8'h00;
        bt[0] = 8'hA5; bt[1] = 8'h5A; bt[2] = 8'hF0; bt[3] = 8'h0F;
        add_burst(bt, 4, 3, 1'b0, 2, 3);
        play();
        n_tests += 5;
        if (ob_rdv[4] !== 1'b1 || ob_rdata[4] !== 16'h5AA5) begin
            n_fail++; $display("FAIL const_pair0 got v=%b %h want v=1 5aa5", ob_rdv[4], ob_rdata[4]);
        end
        if (ob_rdv[5] !== 1'b1 || ob_rdata[5] !== 16'h0FF0) begin
            n_fail++; $display("FAIL const_pair1 got v=%b %h want v=1 0ff0", ob_rdv[5], ob_rdata[5]);
        end
        if (ob_burst[5] !== 64'h0FF05AA5) begin n_fail++; $display("FAIL const_burst got %h want 0ff05aa5", ob_burst[5]); end
        if (ob_err[6] !== 1'b0) begin n_fail++; $display("FAIL const_err got %b want 0", ob_err[6]); end
        if (ob_rdv[3] !== 1'b0) begin n_fail++; $display("FAIL const_latency got v=%b want 0", ob_rdv[3]); end
        for (int i = 0; i < n_pl; i++) begin
            n_tests++;
            if (ob_bv[i] !== ex_bv[i]) begin n_fail++; $display("FAIL const_bv[%0d] got %b want %b", i, ob_bv[i], ex_bv[i]); end
        end
    endtask

    task automatic test_phase_sweep();
        logic [7:0] bt[16];
        for (int k = 0; k < 16; k++) bt[k] = 8'h00;
        bt[0] = 8'hA5; bt[1] = 8'h5A; bt[2] = 8'hF0; bt[3] = 8'h0F;
        for (int s = 0; s < 12; s++) begin
            add_burst(bt, 4, s, 1'b0, 2, 1);
            play();
            n_tests += 3;
            if (ob_rdata[4] !== 16'h5AA5) begin n_fail++; $display("FAIL sweep_pair0 s=%0d got %h want 5aa5", s, ob_rdata[4]); end
            if (ob_bv[5] !== 1'b1) begin n_fail++; $display("FAIL sweep_bv s=%0d got %b want 1", s, ob_bv[5]); end
            if (ob_burst[5] !== 64'h0FF05AA5) begin n_fail++; $display("FAIL sweep_burst s=%0d got %h want 0ff05aa5", s, ob_burst[5]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bt[16];
        for (int k = 0; k < 8; k++) begin bt[k] = 8'(k); bt[8 + k] = 8'(8'h10 + k); end
        add_burst(bt, 16, 5, 1'b1, 8, 2);
        play();
        for (int i = 4; i < n_pl; i++) begin
            n_tests++;
            if (ob_bv[i] !== ((i == 7) || (i == 11))) begin n_fail++; $display("FAIL b2b_bv[%0d] got %b", i, ob_bv[i]); end
            if (i < 12) begin
                n_tests++;
                if (ob_rdata[i] !== ex_rdata[i]) begin n_fail++; $display("FAIL b2b_rdata[%0d] got %h want %h", i, ob_rdata[i], ex_rdata[i]); end
            end
        end
        n_tests += 2;
        if (ob_burst[7] !== 64'h0706050403020100) begin n_fail++; $display("FAIL b2b_burst0 got %h want 0706050403020100", ob_burst[7]); end
        if (ob_burst[11] !== 64'h1716151413121110) begin n_fail++; $display("FAIL b2b_burst1 got %h want 1716151413121110", ob_burst[11]); end
    endtask

    task automatic test_bad_rsel();
        logic [7:0] bt[16];
        stim_t t;
        for (int k = 0; k < 16; k++) bt[k] = 8'h00;
        bt[0] = 8'hA5; bt[1] = 8'h5A; bt[2] = 8'hF0; bt[3] = 8'h0F;
        add_burst(bt, 4, 0, 1'b0, 2, 0);
        t = stq[4]; t.rs = 12'h000; stq[4] = t;
        t = stq[5]; t.rs = 12'h003; stq[5] = t;
        add({$urandom, $urandom}, 12'h001, 1'b0, 1'b0, 1'b1, 1'b0);
        add({$urandom, $urandom}, 12'h005, 1'b1, 1'b0, 1'b1, 1'b0);
        add({$urandom, $urandom}, 12'h001, 1'b0, 1'b0, 1'b0, 1'b0);
        play();
        n_tests += 7;
        if (ob_err[4] !== 1'b1) begin n_fail++; $display("FAIL bad_err_zero got %b want 1", ob_err[4]); end
        if (ob_rdata[4] !== 16'h5AA5) begin n_fail++; $display("FAIL bad_pair0 got %h want 5aa5", ob_rdata[4]); end
        if (ob_rdata[5] !== 16'h0FF0) begin n_fail++; $display("FAIL bad_pair1 got %h want 0ff0", ob_rdata[5]); end
        if (ob_bv[5] !== 1'b1 || ob_burst[5] !== 64'h0FF05AA5) begin
            n_fail++; $display("FAIL bad_burst got v=%b %h want v=1 0ff05aa5", ob_bv[5], ob_burst[5]);
        end
        if (ob_err[6] !== 1'b0) begin n_fail++; $display("FAIL bad_err_clr got %b want 0", ob_err[6]); end
        if (ob_err[7] !== 1'b1) begin n_fail++; $display("FAIL bad_err_clr_vs_new got %b want 1", ob_err[7]); end
        if (ob_rdata[7] !== ex_rdata[7]) begin n_fail++; $display("FAIL bad_pair2 got %h want %h", ob_rdata[7], ex_rdata[7]); end
    endtask

    task automatic test_drop();
        logic [7:0] b8t[16];
        logic [7:0] b4t[16];
        for (int k = 0; k < 16; k++) begin b8t[k] = 8'(8'h30 + k); b4t[k] = 8'h00; end
        b4t[0] = 8'hA5; b4t[1] = 8'h5A; b4t[2] = 8'hF0; b4t[3] = 8'h0F;
        add({$urandom, $urandom}, 12'h001, 1'b0, 1'b0, 1'b1, 1'b0);
        add_burst(b8t, 8, 7, 1'b1, 2, 2);
        add_burst(b4t, 4, 2, 1'b0, 2, 2);
        play();
        n_tests += 3;
        if (ob_err[0] !== 1'b0) begin n_fail++; $display("FAIL drop_err_pre got %b want 0", ob_err[0]); end
        if (ob_err[7] !== 1'b1) begin n_fail++; $display("FAIL drop_err got %b want 1", ob_err[7]); end
        if (ob_bv[14] !== 1'b1 || ob_burst[14] !== 64'h0FF05AA5) begin
            n_fail++; $display("FAIL drop_next_burst got v=%b %h want v=1 0ff05aa5", ob_bv[14], ob_burst[14]);
        end
        for (int i = 1; i < 14; i++) begin
            n_tests++;
            if (ob_bv[i] !== 1'b0) begin n_fail++; $display("FAIL drop_no_bv[%0d] got %b want 0", i, ob_bv[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b8t[16];
        logic [7:0] b4t[16];
        stim_t t;
        for (int k = 0; k < 16; k++) begin b8t[k] = 8'(8'hC0 + k); b4t[k] = 8'h00; end
        b4t[0] = 8'hA5; b4t[1] = 8'h5A; b4t[2] = 8'hF0; b4t[3] = 8'h0F;
        add({$urandom, $urandom}, 12'h001, 1'b0, 1'b0, 1'b1, 1'b0);
        add_burst(b8t, 8, 4, 1'b1, 3, 0);
        t = stq[5]; t.rs = 12'h000; stq[5] = t;
        add({$urandom, $urandom}, 12'h010, 1'b1, 1'b1, 1'b0, 1'b1);
        add_burst(b4t, 4, 6, 1'b0, 2, 2);
        play();
        n_tests += 7;
        if (ob_err[7] !== 1'b1) begin n_fail++; $display("FAIL rstmid_err_pre got %b want 1", ob_err[7]); end
        if (ob_rdata[8] !== 16'h0 || ob_rdv[8] !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_rdata got v=%b %h want v=0 0", ob_rdv[8], ob_rdata[8]);
        end
        if (ob_burst[8] !== 64'h0) begin n_fail++; $display("FAIL rstmid_burst got %h want 0", ob_burst[8]); end
        if (ob_bv[8] !== 1'b0) begin n_fail++; $display("FAIL rstmid_bv got %b want 0", ob_bv[8]); end
        if (ob_err[8] !== 1'b0) begin n_fail++; $display("FAIL rstmid_err got %b want 0", ob_err[8]); end
        if (ob_bv[14] !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_bv got %b want 1", ob_bv[14]); end
        if (ob_burst[14] !== 64'h0FF05AA5) begin n_fail++; $display("FAIL rstmid_next_burst got %h want 0ff05aa5", ob_burst[14]); end
    endtask

    task automatic test_random();
        logic [11:0] rs;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) rs = 12'($urandom);
            else rs = 12'(1 << $urandom_range(0, 11));
            add({$urandom, $urandom}, rs, $urandom_range(0, 9) < 7, 1'($urandom),
                $urandom_range(0, 19) == 0, 1'b0);
        end
        play();
        for (int i = 0; i < n_pl; i++) begin
            n_tests += 3;
            if (ob_rdv[i] !== ex_rdv[i]) begin n_fail++; $display("FAIL rnd_rdv[%0d] got %b want %b", i, ob_rdv[i], ex_rdv[i]); end
            if (ob_bv[i] !== ex_bv[i]) begin n_fail++; $display("FAIL rnd_bv[%0d] got %b want %b", i, ob_bv[i], ex_bv[i]); end
            if (ob_err[i] !== ex_err[i]) begin n_fail++; $display("FAIL rnd_err[%0d] got %b want %b", i, ob_err[i], ex_err[i]); end
            if (ex_rdv[i]) begin
                n_tests++;
                if (ob_rdata[i] !== ex_rdata[i]) begin n_fail++; $display("FAIL rnd_rdata[%0d] got %h want %h", i, ob_rdata[i], ex_rdata[i]); end
            end
            if (ex_bv[i]) begin
                n_tests++;
                if (ob_burst[i] !== ex_burst[i]) begin n_fail++; $display("FAIL rnd_burst[%0d] got %h want %h", i, ob_burst[i], ex_burst[i]); end
            end
        end
    endtask

    initial begin
        for (int c = 0; c < MAXC; c++) words[c] = '0;
        test_reset();
        test_const_phase();
        test_phase_sweep();
        test_back_to_back();
        test_bad_rsel();
        test_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
